// File: rtl/serial_mem_responder_pkg.sv
// serial_mem_responder_pkg: serial bus codes and FSM encodings shared with the CPU side
package serial_mem_responder_pkg;
  localparam int TX_HEADER_READ_16 = 1;
  localparam int TX_HEADER_WRITE_16 = 2;
  localparam int TX_HEADER_WRITE_8 = 3;
  localparam int RESP_START = 1;
  typedef enum logic [1:0] {DEC_IDLE, DEC_ADDR, DEC_DATA} dec_state_e;
  typedef enum logic {TX_IDLE, TX_DATA} tx_state_e;
  function automatic logic [15:0] merge_byte(input logic [15:0] word, input logic [7:0] b, input logic lane);
    return lane ? {b, word[7:0]} : {word[15:8], b};
  endfunction
endpackage

// File: rtl/serial_mem_responder_resp_queue.sv
// serial_mem_responder_resp_queue: shift-register FIFO of read responses, each with a release countdown
module serial_mem_responder_resp_queue #(
  parameter int DEPTH = 2,
  parameter int DELAY = 2,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_data_o,
  output logic         head_ready_o,
  output logic         empty_o,
  output logic         drop_o
);
  localparam int CW = $clog2(DELAY + 2);
  localparam int NW = $clog2(DEPTH + 1);
  logic [W-1:0] data_q [DEPTH];
  logic [W-1:0] data_d [DEPTH];
  logic [CW-1:0] cnt_q [DEPTH];
  logic [CW-1:0] cnt_d [DEPTH];
  logic [NW-1:0] num_q, num_d, slot;
  logic do_pop, do_push;
  assign do_pop = pop_i && num_q != '0;
  assign do_push = push_i && (num_q != NW'(DEPTH) || do_pop);
  assign slot = num_q - NW'(do_pop);
  assign num_d = slot + NW'(do_push);
  assign head_data_o = data_q[0];
  assign head_ready_o = num_q != '0 && cnt_q[0] == '0;
  assign empty_o = num_q == '0;
  assign drop_o = push_i && !do_push;
  // pop shifts toward the head first, so a push into a full queue lands in the freed slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = do_pop ? data_q[(i + 1) % DEPTH] : data_q[i];
      cnt_d[i] = do_pop ? cnt_q[(i + 1) % DEPTH] : cnt_q[i];
      cnt_d[i] = cnt_d[i] == '0 ? '0 : cnt_d[i] - CW'(1);
      if (do_push && NW'(i) == slot) begin
        data_d[i] = push_data_i;
        cnt_d[i] = CW'(DELAY);
      end
    end
  end
  always_ff @(posedge clk) begin
    num_q <= reset ? '0 : num_d;
    data_q <= data_d;
    cnt_q <= cnt_d;
  end
endmodule

// File: rtl/serial_mem_responder.sv
// serial_mem_responder: serial-bus RAM model decoding CPU command frames and returning read responses
module serial_mem_responder
  import serial_mem_responder_pkg::*;
#(
  parameter int IO_BITS = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int ADDR_BITS = 10,
  parameter int RESP_DELAY = 2,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IO_BITS-1:0]   cmd_pins,
  output logic [IO_BITS-1:0]   resp_pins,
  input  logic                 bd_we,
  input  logic [ADDR_BITS-1:0] bd_addr,
  input  logic [15:0]          bd_data,
  output logic                 busy,
  output logic                 overflow
);
  localparam int CW = $clog2(PAYLOAD_CYCLES);
  logic [15:0] mem [2**(ADDR_BITS-1)];
  dec_state_e dec_q, dec_d;
  tx_state_e tx_q, tx_d;
  logic [CW-1:0] cnt_q, cnt_d, tx_cnt_q, tx_cnt_d;
  logic [IO_BITS-1:0] hdr_q, hdr_d;
  logic [15:0] addr_q, addr_d, data_q, data_d, addr_full, data_full, fr_word, head_data;
  logic dec_last, tx_last, rd_push, fr_we, pop, head_ready, q_empty, drop, overflow_q, unused_bd;
  assign dec_last = cnt_q == CW'(PAYLOAD_CYCLES - 1);
  assign tx_last = tx_cnt_q == CW'(PAYLOAD_CYCLES - 1);
  // symbols arrive LSB first, so each one shifts in from the top
  assign addr_full = {cmd_pins, addr_q[15:IO_BITS]};
  assign data_full = {cmd_pins, data_q[15:IO_BITS]};
  assign unused_bd = bd_addr[0];
  always_ff @(posedge clk) begin
    dec_q <= reset ? DEC_IDLE : dec_d;
    cnt_q <= reset ? '0 : cnt_d;
    hdr_q <= hdr_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end
  always_comb begin
    dec_d = dec_q;
    cnt_d = cnt_q;
    hdr_d = hdr_q;
    addr_d = addr_q;
    data_d = data_q;
    case (dec_q)
      DEC_IDLE: if (cmd_pins != '0) begin
        dec_d = DEC_ADDR;
        hdr_d = cmd_pins;
        cnt_d = '0;
      end
      DEC_ADDR: begin
        addr_d = addr_full;
        cnt_d = dec_last ? '0 : cnt_q + CW'(1);
        if (dec_last)
          dec_d = (hdr_q == IO_BITS'(TX_HEADER_WRITE_16) || hdr_q == IO_BITS'(TX_HEADER_WRITE_8)) ? DEC_DATA : DEC_IDLE;
      end
      DEC_DATA: begin
        data_d = data_full;
        cnt_d = dec_last ? '0 : cnt_q + CW'(1);
        if (dec_last) dec_d = DEC_IDLE;
      end
      default: dec_d = DEC_IDLE;
    endcase
  end
  always_comb begin
    rd_push = dec_q == DEC_ADDR && dec_last && hdr_q == IO_BITS'(TX_HEADER_READ_16);
    fr_we = dec_q == DEC_DATA && dec_last;
    fr_word = hdr_q == IO_BITS'(TX_HEADER_WRITE_8) ?
              merge_byte(mem[addr_q[ADDR_BITS-1:1]], data_full[7:0], addr_q[0]) : data_full;
  end
  always_ff @(posedge clk) begin
    if (fr_we) mem[addr_q[ADDR_BITS-1:1]] <= fr_word;
    else if (bd_we) mem[bd_addr[ADDR_BITS-1:1]] <= bd_data;
  end
  serial_mem_responder_resp_queue #(.DEPTH(QUEUE_DEPTH), .DELAY(RESP_DELAY), .W(16)) u_queue (
    .clk(clk),
    .reset(reset),
    .push_i(rd_push),
    .push_data_i(mem[addr_full[ADDR_BITS-1:1]]),
    .pop_i(pop),
    .head_data_o(head_data),
    .head_ready_o(head_ready),
    .empty_o(q_empty),
    .drop_o(drop)
  );
  always_ff @(posedge clk) begin
    tx_q <= reset ? TX_IDLE : tx_d;
    tx_cnt_q <= reset ? '0 : tx_cnt_d;
    overflow_q <= reset ? 1'b0 : overflow_q | drop;
  end
  always_comb begin
    tx_d = tx_q == TX_IDLE ? (head_ready ? TX_DATA : TX_IDLE) : (tx_last ? TX_IDLE : TX_DATA);
    tx_cnt_d = tx_q == TX_DATA ? tx_cnt_q + CW'(1) : '0;
  end
  // start symbol goes out combinationally in the cycle the head becomes ready
  always_comb begin
    pop = tx_q == TX_DATA && tx_last;
    resp_pins = tx_q == TX_DATA ? head_data[tx_cnt_q*IO_BITS +: IO_BITS] :
                head_ready ? IO_BITS'(RESP_START) : '0;
  end
  assign busy = dec_q != DEC_IDLE || !q_empty || tx_q != TX_IDLE;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_serial_mem_responder.sv
// tb_serial_mem_responder: directed frames with a scoreboard checking response data and latency
module tb_serial_mem_responder;
  logic clk = 0, reset = 1;
  logic [1:0] cmd = 0, cmd2 = 0, resp, resp2;
  logic bd_we = 0;
  logic [9:0] bd_addr = 0;
  logic [15:0] bd_data = 0;
  logic busy, busy2, ovf, ovf2;
  int cyc = 0, n_checks = 0, n_fail = 0;
  typedef struct {logic [15:0] data; int cyc;} exp_t;
  exp_t exp_q[$];
  exp_t cur;
  bit mon_en = 1, in_frame = 0;
  int k = 0;
  logic [15:0] word;

  serial_mem_responder u_dut (
    .clk(clk), .reset(reset), .cmd_pins(cmd), .resp_pins(resp), .bd_we(bd_we),
    .bd_addr(bd_addr), .bd_data(bd_data), .busy(busy), .overflow(ovf)
  );
  serial_mem_responder #(.RESP_DELAY(20)) u_dut_slow (
    .clk(clk), .reset(reset), .cmd_pins(cmd2), .resp_pins(resp2), .bd_we(bd_we),
    .bd_addr(bd_addr), .bd_data(bd_data), .busy(busy2), .overflow(ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset || !mon_en) in_frame = 0;
    else if (in_frame) begin
      word[k*2 +: 2] = resp;
      k++;
      if (k == 8) begin
        in_frame = 0;
        check("resp_data", word, cur.data);
      end
    end else if (resp != 0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got symbol %0d with no expected response (cycle %0d)", resp, cyc);
      end else begin
        cur = exp_q.pop_front();
        check("resp_start", resp, 1);
        check("resp_latency", cyc, cur.cyc);
        in_frame = 1;
        k = 0;
        word = 0;
      end
    end
  end

  task automatic send(input bit which, input logic [1:0] s);
    @(posedge clk);
    #1;
    bd_we = 0;
    if (which) cmd2 = s;
    else cmd = s;
  endtask

  task automatic frame(input bit which, input logic [1:0] hdr, input logic [15:0] addr,
                       input logic [15:0] data, input bit collide, output int t);
    send(which, hdr);
    for (int i = 0; i < 8; i++) send(which, addr[2*i +: 2]);
    t = cyc;
    if (hdr != 2'd1)
      for (int i = 0; i < 8; i++) begin
        send(which, data[2*i +: 2]);
        if (collide && i == 7) begin
          bd_we = 1;
          bd_addr = addr[9:0];
          bd_data = 16'h1111;
        end
      end
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp);
    int t;
    frame(0, 2'd1, addr, 16'h0, 0, t);
    exp_q.push_back('{exp, t + 3});
  endtask

  task automatic wr(input logic [1:0] hdr, input logic [15:0] addr, input logic [15:0] data, input bit collide);
    int t;
    frame(0, hdr, addr, data, collide, t);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_within_bound", n < 200, 1);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset_resp", resp, 0);
    check("reset_busy", busy, 0);
    check("reset_overflow", ovf, 0);
    @(posedge clk);
    #1 bd_we = 1; bd_addr = 10'h010; bd_data = 16'h1234;
    @(posedge clk);
    #1 bd_we = 0;
    rd(16'h0010, 16'h1234);
    @(negedge clk);
    check("busy_in_frame", busy, 1);
    send(0, 0);
    drain();
    wr(2'd2, 16'h0020, 16'hBEEF, 0);
    rd(16'h0021, 16'hBEEF);
    send(0, 0);
    drain();
    wr(2'd3, 16'h0021, 16'h55AA, 0);
    rd(16'h0020, 16'hAAEF);
    send(0, 0);
    drain();
    rd(16'h0010, 16'h1234);
    rd(16'h0020, 16'hAAEF);
    send(0, 0);
    drain();
    rd(16'h0410, 16'h1234);
    send(0, 0);
    drain();
    wr(2'd2, 16'h0030, 16'hC0DE, 1);
    send(0, 0);
    rd(16'h0030, 16'hC0DE);
    send(0, 0);
    drain();
    frame(1, 2'd1, 16'h0010, 16'h0, 0, t);
    frame(1, 2'd1, 16'h0010, 16'h0, 0, k);
    frame(1, 2'd1, 16'h0010, 16'h0, 0, k);
    @(negedge clk);
    check("slow_overflow_before_drop", ovf2, 0);
    send(1, 0);
    @(negedge clk);
    check("slow_overflow_after_drop", ovf2, 1);
    check("fast_overflow_clear", ovf, 0);
    wait_until(t + 20);
    check("slow_before_start", resp2, 0);
    wait_until(t + 21);
    check("slow_start", resp2, 1);
    wait_until(t + 28);
    check("slow_sym6", resp2, 1);
    wait_until(t + 30);
    check("slow_second_start", resp2, 1);
    wait_until(t + 39);
    check("slow_no_third_frame", resp2, 0);
    check("slow_idle_busy", busy2, 0);
    check("slow_overflow_sticky", ovf2, 1);
    mon_en = 0;
    frame(0, 2'd1, 16'h0010, 16'h0, 0, t);
    send(0, 0);
    wait_until(t + 6);
    check("mid_resp_sym2", resp, 3);
    check("mid_resp_busy", busy, 1);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("abort_resp", resp, 0);
    check("abort_busy", busy, 0);
    check("abort_overflow_cleared", ovf2, 0);
    @(negedge clk);
    check("abort_queue_flushed", resp, 0);
    mon_en = 1;
    rd(16'h0020, 16'hAAEF);
    send(0, 0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
